cc_tag_compare: RTL

//  Lookup stage directly downstream of the address decoder: consumes each accepted request
//  (hs_pulse_i with tag/index/offset), reads the tag+valid array at index, compares and pushes
//  the result into the hit-flag FIFO and, on a miss, into the miss-address and miss-request FIFOs.

---
 rtl/cc_tag_compare_if.sv | 47 ++++
 rtl/cc_tag_compare.sv | 105 ++++++++++
 2 files changed

// File: rtl/cc_tag_compare_if.sv
// Purpose: request, fill and FIFO-push bundle of the tag-compare lookup stage.
// Latency: none, wiring only.
// Backpressure: none carried here; the decoder gates hs_pulse_i on FIFO almost-full.
// Signals: request (hs_pulse_i, tag_i, index_i, offset_i), fill port (fill_valid_i,
//   fill_index_i, fill_tag_i), FIFO pushes (hit_flag_*, miss_addr_*, miss_req_*),
//   and miss tracking (out_cnt_o, miss_afull_o).
interface cc_tag_compare_if #(
  parameter int TAG_W = 17,
  parameter int IDX_W = 9,
  parameter int OFS_W = 6
);
  logic             hs_pulse_i;
  logic [TAG_W-1:0] tag_i;
  logic [IDX_W-1:0] index_i;
  logic [OFS_W-1:0] offset_i;
  logic             fill_valid_i;
  logic [IDX_W-1:0] fill_index_i;
  logic [TAG_W-1:0] fill_tag_i;
  logic             hit_flag_wren_o;
  logic             hit_flag_wdata_o;
  logic             miss_addr_wren_o;
  logic [31:0]      miss_addr_wdata_o;
  logic             miss_req_wren_o;
  logic [31:0]      miss_req_wdata_o;
  logic [3:0]       out_cnt_o;
  logic             miss_afull_o;

  // Upstream side: decoder plus refill path.
  modport master (
    output hs_pulse_i, tag_i, index_i, offset_i,
    output fill_valid_i, fill_index_i, fill_tag_i,
    input  hit_flag_wren_o, hit_flag_wdata_o,
    input  miss_addr_wren_o, miss_addr_wdata_o,
    input  miss_req_wren_o, miss_req_wdata_o,
    input  out_cnt_o, miss_afull_o
  );

  // Lookup stage side.
  modport slave (
    input  hs_pulse_i, tag_i, index_i, offset_i,
    input  fill_valid_i, fill_index_i, fill_tag_i,
    output hit_flag_wren_o, hit_flag_wdata_o,
    output miss_addr_wren_o, miss_addr_wdata_o,
    output miss_req_wren_o, miss_req_wdata_o,
    output out_cnt_o, miss_afull_o
  );
endinterface

// File: rtl/cc_tag_compare.sv
// Purpose: direct-mapped tag/valid lookup; pushes hit flag, and miss addr/req on a miss.
// Latency: 1 cycle from hs_pulse_i to FIFO push; one lookup per cycle, no bubbles.
// Backpressure: none; upstream gates hs_pulse_i using miss_afull_o / FIFO almost-full.
// Ports: clk, rst (sync, active-high); bus (slave modport): request, fill port,
//   hit-flag / miss-address / miss-request FIFO pushes, outstanding-miss count and afull.
module cc_tag_compare #(
  parameter int TAG_W   = 17,
  parameter int IDX_W   = 9,
  parameter int OFS_W   = 6,
  parameter int MAX_OUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  cc_tag_compare_if.slave    bus
);

  localparam int         DEPTH    = 1 << IDX_W;
  localparam logic [3:0] CNT_MAX  = 4'(MAX_OUT);
  localparam logic [3:0] AFULL_TH = 4'(MAX_OUT - 1);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic             s1_vld;
  logic [TAG_W-1:0] s1_tag;
  logic [IDX_W-1:0] s1_idx;
  logic [OFS_W-1:0] s1_ofs;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;

  logic             fwd;
  logic             hit;
  logic             push;
  logic             miss_push;
  logic [3:0]       cnt_q;

  // Fill landing on the index being looked up this cycle wins (write-first).
  assign fwd = bus.fill_valid_i && (bus.fill_index_i == bus.index_i);

  // Valid bits live in flops so the whole array clears in the single reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (bus.fill_valid_i) begin
      valid_q[bus.fill_index_i] <= 1'b1;
    end
  end

  // Tags need no reset: they are only meaningful behind a set valid bit.
  always_ff @(posedge clk) begin
    if (bus.fill_valid_i) begin
      tag_mem[bus.fill_index_i] <= bus.fill_tag_i;
    end
  end

  // Stage 0: capture request and do the registered array read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_tag   <= '0;
      s1_idx   <= '0;
      s1_ofs   <= '0;
      rd_valid <= 1'b0;
      rd_tag   <= '0;
    end else begin
      s1_vld <= bus.hs_pulse_i;
      if (bus.hs_pulse_i) begin
        s1_tag   <= bus.tag_i;
        s1_idx   <= bus.index_i;
        s1_ofs   <= bus.offset_i;
        rd_valid <= fwd ? 1'b1 : valid_q[bus.index_i];
        rd_tag   <= fwd ? bus.fill_tag_i : tag_mem[bus.index_i];
      end
    end
  end

  // Stage 1: compare and push. Gating with rst drops a request caught in stage 1
  // while reset is asserted.
  assign hit       = rd_valid && (rd_tag == s1_tag);
  assign push      = s1_vld && !rst;
  assign miss_push = push && !hit;

  assign bus.hit_flag_wren_o   = push;
  assign bus.hit_flag_wdata_o  = push && hit;
  assign bus.miss_addr_wren_o  = miss_push;
  assign bus.miss_req_wren_o   = miss_push;
  assign bus.miss_addr_wdata_o = miss_push ? 32'({s1_tag, s1_idx, s1_ofs}) : 32'd0;
  assign bus.miss_req_wdata_o  = miss_push ? 32'({s1_tag, s1_idx, {OFS_W{1'b0}}}) : 32'd0;

  // Outstanding misses: a miss and a fill in the same cycle cancel out. Saturates
  // at CNT_MAX; a fill with nothing outstanding leaves the count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (miss_push && !bus.fill_valid_i) begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 4'd1;
    end else if (!miss_push && bus.fill_valid_i) begin
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end
  end

  assign bus.out_cnt_o    = cnt_q;
  assign bus.miss_afull_o = (cnt_q >= AFULL_TH);

endmodule
